// File: rtl/lcm_pkt_buf_if.sv
// LCM word bus: 134-bit word, write strobe, packet-end commit/valid strobes and a ready back-channel.
// The master drives the word and strobes, the slave drives ready.
interface lcm_pkt_buf_if;
    logic [133:0] data;
    logic         data_wr;
    logic         data_valid;
    logic         data_valid_wr;
    logic         data_ready;

    modport master (
        output data,
        output data_wr,
        output data_valid,
        output data_valid_wr,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_wr,
        input  data_valid,
        input  data_valid_wr,
        output data_ready
    );
endinterface

// File: rtl/lcm_pkt_buf.sv
// LCM packet buffer: stores words from the register-read responder, commits or rolls back whole
// packets on the packet-end strobe, and replays committed packets with packet-level backpressure.
// Optional statistics counters are enabled by defining LCM_PKT_BUF_STAT_EN.
module lcm_pkt_buf #(
    parameter int unsigned DATA_DEPTH   = 64,
    parameter int unsigned PKT_DEPTH    = 16,
    parameter int unsigned AFULL_MARGIN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcm_pkt_buf_if.slave         lcm_in,
    lcm_pkt_buf_if.master        lcm_out
`ifdef LCM_PKT_BUF_STAT_EN
    ,
    output logic [31:0]          pkt_in_cnt,
    output logic [31:0]          pkt_out_cnt,
    output logic [31:0]          pkt_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DATA_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(PKT_DEPTH);

    localparam logic [LW-1:0] DEPTH_L     = DATA_DEPTH[LW-1:0];
    localparam logic [PW:0]   PKT_DEPTH_L = PKT_DEPTH[PW:0];
    localparam logic [LW-1:0] LEN_ONE     = LW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Storage
    logic [133:0]  mem_q      [DATA_DEPTH];
    logic [LW-1:0] desc_mem_q [PKT_DEPTH];

    // Write side
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] pkt_start_q, pkt_start_d;
    logic [LW-1:0] cur_len_q, cur_len_d;
    logic          drop_q, drop_d;
    logic [LW-1:0] occ_q, occ_d;
    logic          in_ready_q, in_ready_d;

    // Descriptor FIFO
    logic [PW-1:0] desc_wr_q, desc_wr_d;
    logic [PW-1:0] desc_rd_q, desc_rd_d;
    logic [PW:0]   desc_cnt_q, desc_cnt_d;

    // Read side
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [133:0]  out_data_q, out_data_d;
    logic          out_wr_q, out_wr_d;
    logic          out_last_q, out_last_d;

    // Decoded events
    logic          full, wr_store, wr_drop, desc_full, commit, rollback, pop, rd_word, last_word;
    logic [LW-1:0] pkt_len, free_words;

    // Event decode shared by the write side, read FSM and counters
    always_comb begin
        full       = (occ_q == DEPTH_L);
        wr_store   = lcm_in.data_wr && !full;
        wr_drop    = lcm_in.data_wr && full;
        // Length includes the word written alongside the packet-end strobe
        pkt_len    = cur_len_q + (wr_store ? LEN_ONE : '0);
        desc_full  = (desc_cnt_q == PKT_DEPTH_L);
        commit     = lcm_in.data_valid_wr && lcm_in.data_valid && !drop_q && !wr_drop &&
                     (pkt_len != '0) && !desc_full;
        rollback   = lcm_in.data_valid_wr && !commit;
        pop        = (state_q == ST_IDLE) && (desc_cnt_q != '0) && lcm_out.data_ready;
        rd_word    = (state_q == ST_SEND);
        last_word  = rd_word && (rem_q == LEN_ONE);
        free_words = DEPTH_L - occ_q;
    end

    // Write pointer, packet start, length, drop flag, occupancy and input ready
    always_comb begin
        wr_ptr_d    = wr_ptr_q + (wr_store ? AW'(1) : '0);
        pkt_start_d = pkt_start_q;
        cur_len_d   = wr_store ? pkt_len : cur_len_q;
        drop_d      = drop_q || wr_drop;
        occ_d       = occ_q + (wr_store ? LEN_ONE : '0) - (rd_word ? LEN_ONE : '0);
        if (lcm_in.data_valid_wr) begin
            cur_len_d = '0;
            drop_d    = 1'b0;
            if (commit) begin
                pkt_start_d = wr_ptr_d;
            end else begin
                // Only in-flight words are released; committed data is untouched
                wr_ptr_d = pkt_start_q;
                occ_d    = occ_d - pkt_len;
            end
        end
        // Registered from the current occupancy, so ready lags it by one cycle
        in_ready_d = ({{(32 - LW){1'b0}}, free_words} >= AFULL_MARGIN) && !desc_full;
    end

    // Descriptor FIFO pointers and count
    always_comb begin
        desc_wr_d  = desc_wr_q + (commit ? PW'(1) : '0);
        desc_rd_d  = desc_rd_q + (pop ? PW'(1) : '0);
        desc_cnt_d = desc_cnt_q + (commit ? (PW + 1)'(1) : '0) - (pop ? (PW + 1)'(1) : '0);
    end

    // Read FSM: IDLE waits for a descriptor and downstream ready, SEND streams one packet
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rem_d      = rem_q;
        out_data_d = '0;
        out_wr_d   = 1'b0;
        out_last_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rem_d   = desc_mem_q[desc_rd_q];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                out_data_d = mem_q[rd_ptr_q];
                out_wr_d   = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rem_d      = rem_q - LEN_ONE;
                if (last_word) begin
                    out_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            cur_len_q   <= '0;
            drop_q      <= 1'b0;
            occ_q       <= '0;
            in_ready_q  <= 1'b1;
            desc_wr_q   <= '0;
            desc_rd_q   <= '0;
            desc_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            cur_len_q   <= cur_len_d;
            drop_q      <= drop_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            desc_wr_q   <= desc_wr_d;
            desc_rd_q   <= desc_rd_d;
            desc_cnt_q  <= desc_cnt_d;
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_wr_q    <= out_wr_d;
            out_last_q  <= out_last_d;
        end
    end

    // Word and descriptor storage; contents are don't-care until pointers cover them
    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem_q[wr_ptr_q] <= lcm_in.data;
        end
        if (commit) begin
            desc_mem_q[desc_wr_q] <= pkt_len;
        end
    end

    assign lcm_in.data_ready     = in_ready_q;
    assign lcm_out.data          = out_data_q;
    assign lcm_out.data_wr       = out_wr_q;
    assign lcm_out.data_valid    = out_last_q;
    assign lcm_out.data_valid_wr = out_last_q;

`ifdef LCM_PKT_BUF_STAT_EN
    logic [31:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;

    // Packet statistics, wrapping at 2^32
    always_comb begin
        in_cnt_d   = in_cnt_q + (commit ? 32'd1 : 32'd0);
        out_cnt_d  = out_cnt_q + (last_word ? 32'd1 : 32'd0);
        drop_cnt_d = drop_cnt_q + (rollback ? 32'd1 : 32'd0);
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_in_cnt   = in_cnt_q;
    assign pkt_out_cnt  = out_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lcm_pkt_buf.sv
// Directed bench for lcm_pkt_buf: a 64-deep instance for the main scenarios and an 8-deep
// instance for overflow. Expected words are queued when driven and compared on output.
module tb_lcm_pkt_buf;

    typedef struct packed {
        logic [133:0] d;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcm_pkt_buf_if m_in ();
    lcm_pkt_buf_if m_out ();
    lcm_pkt_buf_if s_in ();
    lcm_pkt_buf_if s_out ();

`ifdef LCM_PKT_BUF_STAT_EN
    logic [31:0] m_in_cnt, m_out_cnt, m_drop_cnt, s_in_cnt, s_out_cnt, s_drop_cnt;
`endif

    lcm_pkt_buf #(.DATA_DEPTH(64), .PKT_DEPTH(16), .AFULL_MARGIN(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcm_in       (m_in),
        .lcm_out      (m_out)
`ifdef LCM_PKT_BUF_STAT_EN
        ,
        .pkt_in_cnt   (m_in_cnt),
        .pkt_out_cnt  (m_out_cnt),
        .pkt_drop_cnt (m_drop_cnt)
`endif
    );

    lcm_pkt_buf #(.DATA_DEPTH(8), .PKT_DEPTH(16), .AFULL_MARGIN(8)) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcm_in       (s_in),
        .lcm_out      (s_out)
`ifdef LCM_PKT_BUF_STAT_EN
        ,
        .pkt_in_cnt   (s_in_cnt),
        .pkt_out_cnt  (s_out_cnt),
        .pkt_drop_cnt (s_drop_cnt)
`endif
    );

    exp_t exp_m[$];
    exp_t exp_s[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   words_m = 0;
    int   words_s = 0;
    int   mark_m = 0;
    int   last_cyc_m = 0;

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of output from both instances against their queues
    task automatic monitor();
        exp_t e;
        if (m_out.data_wr === 1'b1) begin
            words_m++;
            last_cyc_m = cyc;
            if (mark_m < 0) mark_m = cyc;
            chk("m_sb_pending", 134'(exp_m.size() != 0), 134'd1);
            if (exp_m.size() != 0) begin
                e = exp_m.pop_front();
                chk("m_data", m_out.data, e.d);
                chk("m_valid", 134'(m_out.data_valid), 134'(e.last));
                chk("m_valid_wr", 134'(m_out.data_valid_wr), 134'(e.last));
            end
        end else begin
            chk("m_idle_strobes", 134'({m_out.data_valid, m_out.data_valid_wr}), 134'd0);
        end
        if (s_out.data_wr === 1'b1) begin
            words_s++;
            chk("s_sb_pending", 134'(exp_s.size() != 0), 134'd1);
            if (exp_s.size() != 0) begin
                e = exp_s.pop_front();
                chk("s_data", s_out.data, e.d);
                chk("s_valid", 134'(s_out.data_valid), 134'(e.last));
                chk("s_valid_wr", 134'(s_out.data_valid_wr), 134'(e.last));
            end
        end else begin
            chk("s_idle_strobes", 134'({s_out.data_valid, s_out.data_valid_wr}), 134'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic idle_inputs();
        m_in.data = '0; m_in.data_wr = 1'b0; m_in.data_valid = 1'b0; m_in.data_valid_wr = 1'b0;
        s_in.data = '0; s_in.data_wr = 1'b0; s_in.data_valid = 1'b0; s_in.data_valid_wr = 1'b0;
    endtask

    // Drive an n-word packet to instance sel (0 main, 1 small); optionally queue it as expected
    task automatic send_pkt(input bit sel, input int n, input bit vld, input bit expect_out);
        logic [133:0] w;
        exp_t         e;
        for (int i = 0; i < n; i++) begin
            w[133:132] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
            w[131:128] = 4'($urandom);
            w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
            if (!sel) begin
                m_in.data = w; m_in.data_wr = 1'b1;
                m_in.data_valid_wr = (i == n - 1); m_in.data_valid = vld && (i == n - 1);
            end else begin
                s_in.data = w; s_in.data_wr = 1'b1;
                s_in.data_valid_wr = (i == n - 1); s_in.data_valid = vld && (i == n - 1);
            end
            if (expect_out) begin
                e.d = w;
                e.last = (i == n - 1);
                if (!sel) exp_m.push_back(e);
                else exp_s.push_back(e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic drain_m(input int budget);
        int k = 0;
        while (exp_m.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_m", 134'(exp_m.size()), 134'd0);
    endtask

    task automatic drain_s(input int budget);
        int k = 0;
        while (exp_s.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_s", 134'(exp_s.size()), 134'd0);
    endtask

    initial begin
        int wm;
        int k;
        rst_n = 1'b0;
        idle_inputs();
        m_out.data_ready = 1'b1;
        s_out.data_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_wr", 134'(m_out.data_wr), 134'd0);
        chk("rst_out_data", m_out.data, 134'd0);
        chk("rst_out_vwr", 134'({m_out.data_valid, m_out.data_valid_wr}), 134'd0);
        chk("rst_in_ready", 134'(m_in.data_ready), 134'd1);
        chk("rst_s_in_ready", 134'(s_in.data_ready), 134'd1);
        rst_n = 1'b1;
        tick();

        // 6-word packet with first output word two edges after commit
        send_pkt(0, 6, 1'b1, 1'b1);
        chk("lat_n", 134'(m_out.data_wr), 134'd0);
        tick();
        chk("lat_n1", 134'(m_out.data_wr), 134'd0);
        tick();
        chk("lat_n2", 134'(m_out.data_wr), 134'd1);
        drain_m(20);
        chk("p1_words", 134'(words_m), 134'd6);

        // Three packets held by out_ready=0, then released back-to-back
        m_out.data_ready = 1'b0;
        for (int p = 0; p < 3; p++) send_pkt(0, 6, 1'b1, 1'b1);
        wm = words_m;
        repeat (10) tick();
        chk("hold_no_output", 134'(words_m), 134'(wm));
        mark_m = -1;
        m_out.data_ready = 1'b1;
        drain_m(40);
        chk("b2b_span", 134'(last_cyc_m - mark_m), 134'd19);
        chk("b2b_words", 134'(words_m), 134'(wm + 18));

        // Discarded packet, then a packet written over the rolled-back space
        send_pkt(0, 6, 1'b0, 1'b0);
        wm = words_m;
        repeat (8) tick();
        chk("discard_no_output", 134'(words_m), 134'(wm));
        send_pkt(0, 6, 1'b1, 1'b1);
        drain_m(20);
        chk("after_discard_words", 134'(words_m), 134'(wm + 6));
        chk("m_in_ready_idle", 134'(m_in.data_ready), 134'd1);
`ifdef LCM_PKT_BUF_STAT_EN
        chk("stat_in", 134'(m_in_cnt), 134'd5);
        chk("stat_out", 134'(m_out_cnt), 134'd5);
        chk("stat_drop", 134'(m_drop_cnt), 134'd1);
`endif

        // Overflow on the 8-deep instance
        send_pkt(1, 6, 1'b1, 1'b1);
        repeat (2) tick();
        chk("s_ready_low", 134'(s_in.data_ready), 134'd0);
        send_pkt(1, 6, 1'b1, 1'b0);
        repeat (4) tick();
        chk("s_held", 134'(words_s), 134'd0);
        s_out.data_ready = 1'b1;
        drain_s(20);
        repeat (3) tick();
        chk("s_words", 134'(words_s), 134'd6);
        chk("s_ready_back", 134'(s_in.data_ready), 134'd1);
`ifdef LCM_PKT_BUF_STAT_EN
        chk("s_stat_in", 134'(s_in_cnt), 134'd1);
        chk("s_stat_drop", 134'(s_drop_cnt), 134'd1);
`endif

        // 20 packets through the wrapping pointers
        wm = words_m;
        for (int p = 0; p < 20; p++) begin
            k = 0;
            while (m_in.data_ready !== 1'b1 && k < 50) begin
                tick();
                k++;
            end
            chk("wrap_ready", 134'(m_in.data_ready), 134'd1);
            send_pkt(0, 6, 1'b1, 1'b1);
        end
        drain_m(200);
        chk("wrap_words", 134'(words_m), 134'(wm + 120));

        // Reset in the middle of a replay
        send_pkt(0, 6, 1'b1, 1'b1);
        k = 0;
        while (m_out.data_wr !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("send_seen", 134'(m_out.data_wr), 134'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 134'(m_out.data_wr), 134'd0);
        chk("mid_rst_data", m_out.data, 134'd0);
        chk("mid_rst_vwr", 134'({m_out.data_valid, m_out.data_valid_wr}), 134'd0);
        exp_m.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wm = words_m;
        repeat (6) tick();
        chk("post_rst_empty", 134'(words_m), 134'(wm));
        chk("post_rst_ready", 134'(m_in.data_ready), 134'd1);
`ifdef LCM_PKT_BUF_STAT_EN
        chk("post_rst_stat_in", 134'(m_in_cnt), 134'd0);
`endif
        send_pkt(0, 6, 1'b1, 1'b1);
        drain_m(20);
        chk("post_rst_words", 134'(words_m), 134'(wm + 6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
